// File: rtl/apb_arbiter.sv
// Round-robin APB master that shares one completer among NR held requesters.
// Request-to-ack is 3 cycles on a zero-wait slave (+1 per wait state); back-to-back grants every 2 cycles.
module apb_arbiter #(
   parameter int NR      = 4,
   parameter int AW      = 12,
   parameter int DW      = 32,
   parameter int TIMEOUT = 0
) (
   input  logic               PCLK,
   input  logic               PRESET,
   input  logic [NR-1:0]      i_req,
   input  logic [NR*AW-1:0]   i_addr,
   input  logic [NR-1:0]      i_write,
   input  logic [NR*DW-1:0]   i_wdata,
   input  logic [NR*DW/8-1:0] i_wstrb,
   output logic [NR-1:0]      o_ack,
   output logic [DW-1:0]      o_rdata,
   output logic               o_err,
   output logic [NR-1:0]      o_grant,
   output logic               PSEL,
   output logic               PENABLE,
   output logic [AW-1:0]      PADDR,
   output logic               PWRITE,
   output logic [DW-1:0]      PWDATA,
   output logic [DW/8-1:0]    PWSTRB,
   output logic [2:0]         PPROT,
   input  logic               PREADY,
   input  logic [DW-1:0]      PRDATA,
   input  logic               PSLVERR
);
   localparam int SW   = DW / 8;
   localparam int IW   = $clog2(NR);
   localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] gidx;
   logic [CW-1:0] wcnt;

   logic [NR-1:0] arb_req;
   logic [IW-1:0] arb_base;
   logic [IW-1:0] arb_idx;
   logic          arb_found;
   logic          timeout_hit;

   logic [AW-1:0] sel_addr;
   logic          sel_write;
   logic [DW-1:0] sel_wdata;
   logic [SW-1:0] sel_wstrb;

   assign PPROT       = 3'b000;
   assign timeout_hit = (TIMEOUT > 0) && (wcnt == CW'(TLIM));

   // On a completion the finishing requester is masked so it can never win its own ack cycle.
   always_comb begin
      arb_req  = i_req;
      arb_base = last_grant;
      if (state == ACCESS) begin
         arb_req  = i_req & ~o_grant;
         arb_base = gidx;
      end
   end

   // Scan downward so the nearest set bit above the base is the one that sticks.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = NR; i >= 1; i--) begin
         if (arb_req[(int'(arb_base) + i) % NR]) begin
            arb_found = 1'b1;
            arb_idx   = IW'((int'(arb_base) + i) % NR);
         end
      end
   end

   assign sel_addr  = i_addr[int'(arb_idx)*AW +: AW];
   assign sel_write = i_write[arb_idx];
   assign sel_wdata = i_wdata[int'(arb_idx)*DW +: DW];
   assign sel_wstrb = i_wstrb[int'(arb_idx)*SW +: SW];

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state      <= IDLE;
         last_grant <= IW'(NR - 1);
         gidx       <= '0;
         wcnt       <= '0;
         o_ack      <= '0;
         o_rdata    <= '0;
         o_err      <= 1'b0;
         o_grant    <= '0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PADDR      <= '0;
         PWRITE     <= 1'b0;
         PWDATA     <= '0;
         PWSTRB     <= '0;
      end else begin
         o_ack <= '0;
         o_err <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_found) begin
                  PADDR   <= sel_addr;
                  PWRITE  <= sel_write;
                  PWDATA  <= sel_wdata;
                  PWSTRB  <= sel_wstrb;
                  gidx    <= arb_idx;
                  o_grant <= NR'(1) << arb_idx;
                  PSEL    <= 1'b1;
                  PENABLE <= 1'b0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               wcnt    <= '0;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  o_ack      <= o_grant;
                  o_rdata    <= PRDATA;
                  o_err      <= PSLVERR;
                  last_grant <= gidx;
                  if (arb_found) begin
                     PADDR   <= sel_addr;
                     PWRITE  <= sel_write;
                     PWDATA  <= sel_wdata;
                     PWSTRB  <= sel_wstrb;
                     gidx    <= arb_idx;
                     o_grant <= NR'(1) << arb_idx;
                     PENABLE <= 1'b0;
                     state   <= SETUP;
                  end else begin
                     PSEL    <= 1'b0;
                     PENABLE <= 1'b0;
                     o_grant <= '0;
                     state   <= IDLE;
                  end
               end else if (timeout_hit) begin
                  // Abort leaves o_rdata alone and always returns to IDLE.
                  o_ack      <= o_grant;
                  o_err      <= 1'b1;
                  last_grant <= gidx;
                  PSEL       <= 1'b0;
                  PENABLE    <= 1'b0;
                  o_grant    <= '0;
                  state      <= IDLE;
               end else if (TIMEOUT > 0) begin
                  wcnt <= wcnt + CW'(1);
               end
            end
            default: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
               o_grant <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Round-robin arbiter that shares a single APB slave (e.g. the demonstration memory slave) among NR local requesters. Each requester presents a held request with address, direction, data and strobes. The arbiter sequences the APB SETUP/ACCESS phases as the sole APB master, then returns read data and error status with a one-cycle acknowledge. It sits between on-chip request sources and one APB completer.

## Interface
- NR, 4: number of requesters, 2..8
- AW, 12: APB address width
- DW, 32: APB data width (8, 16, 32, 64)
- TIMEOUT, 0: maximum ACCESS cycles without PREADY before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic is rising-edge
- PRESET  in  1  asynchronous, active-high reset
- i_req  in  NR  per-requester request, held until acknowledged
- i_addr  in  NR*AW  packed addresses, requester k at [k*AW +: AW]
- i_write  in  NR  per-requester direction, 1 = write
- i_wdata  in  NR*DW  packed write data
- i_wstrb  in  NR*DW/8  packed byte strobes
- o_ack  out  NR  one-hot, one-cycle completion pulse
- o_rdata  out  DW  read data; valid while o_ack is non-zero
- o_err  out  1  PSLVERR or timeout of the acknowledged transfer; valid with o_ack
- o_grant  out  NR  one-hot owner of the current APB transfer, 0 when idle
- PSEL, PENABLE  out  1 each  APB master controls
- PADDR  out  AW; PWRITE  out  1; PWDATA  out  DW; PWSTRB  out  DW/8; PPROT  out  3 (constant 3'b000)
- PREADY  in  1; PRDATA  in  DW; PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any i_req bit is set, select the first set bit searching upward (mod NR) from last_grant+1.
  - Register PADDR, PWRITE, PWDATA and PWSTRB from the selected slice.
  - Set PSEL=1, PENABLE=0 and o_grant to the winner; go to SETUP.
- SETUP: PENABLE<=1; go to ACCESS. The address, control and data registers do not change.
- ACCESS with PREADY=1:
  - o_ack[grant]<=1, o_rdata<=PRDATA (writes also capture it; it is don't-care), o_err<=PSLVERR.
  - last_grant<=grant.
  - Re-arbitrate in the same cycle with the completing requester masked out.
  - If there is a winner: load the new transfer, keep PSEL=1, set PENABLE=0, go to SETUP (back-to-back transfer).
  - Otherwise: PSEL<=0, PENABLE<=0, o_grant<=0, go to IDLE.
- ACCESS with PREADY=0: hold all outputs. When TIMEOUT>0, increment the wait counter.
- Timeout: when the wait counter reaches TIMEOUT-1 and PREADY is still 0, acknowledge the grantee with o_err=1 and o_rdata unchanged. PSEL and PENABLE drop and the FSM forces IDLE; there is no back-to-back transfer after a timeout.
- The wait counter is $clog2(TIMEOUT+1) bits and clears on every entry to ACCESS.
- Requester rule: i_req[k] must be low in the cycle after o_ack[k]; a new request may be raised from the second cycle onward. Requester inputs are sampled only at arbitration.
- A request withdrawn before grant is legal and is ignored. A request withdrawn after grant still completes and is still acknowledged.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM=IDLE; PSEL, PENABLE, o_ack, o_err, o_grant all 0.
  - PADDR, PWDATA, PWSTRB, PWRITE, o_rdata all 0.
  - last_grant=NR-1, so requester 0 wins first.
- Zero-wait slave: i_req rises before edge 0. PSEL is high after edge 0, PENABLE after edge 1, PREADY is sampled at edge 2, and o_ack is high after edge 2. Request-to-ack is 3 cycles.
- Back-to-back throughput: one transfer per 2 cycles with no PSEL gap.
- Each wait state adds one cycle.
- Reset mid-transfer: outputs return immediately to their reset values; no ack is issued for the aborted transfer.
- APB rules: PENABLE is never high without PSEL. PADDR, PWRITE, PWDATA and PWSTRB are stable from SETUP until PREADY.

## Test plan
- Single write then read, requester 2, zero-wait slave:
  - Stimulus: write 0x12345678 with strobes 4'hF to address 0x010, then read 0x010.
  - Required: each ack 3 cycles after its request; read returns o_rdata=0x12345678 with o_err=0.
- All 4 requesters request simultaneously from reset: grants are issued 0,1,2,3 back-to-back, PSEL stays high for 8 cycles, and each o_ack fires exactly once.
- Fairness: requesters 0 and 1 re-request continuously. Grants alternate 0,1,0,1; the grantee is never re-granted on its own completion cycle.
- Wait states and timeout:
  - Slave inserts 2 wait states: ack arrives at cycle 5 with address and data stable throughout.
  - TIMEOUT=4 with PREADY held low: after 4 ACCESS cycles o_err=1, o_ack pulses, PSEL=0.
- Slave error: PSLVERR=1 alongside PREADY on a read from requester 3 gives o_ack[3]=1 and o_err=1.
- Reset asserted during ACCESS: PSEL, PENABLE and o_grant go to 0 asynchronously. After release, requester 0 wins the first arbitration.
